// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART boot-time program loader.
package prog_loader_pkg;
    typedef enum logic [1:0] {LEN, DATA, DONE, ERR} loader_state_t;
    localparam int UART_BITS = 8;
endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit glitch reject, mid-bit sampling.
// Emits a one-cycle byte_valid or frame_err_pulse at the stop-bit sample; start_valid when a start bit is confirmed.
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err_pulse,
    output logic       start_valid
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rx_meta         <= 1'b1;
            rx_sync         <= 1'b1;
            rx_prev         <= 1'b1;
            state           <= RX_IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            rx_byte         <= '0;
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
            start_valid     <= 1'b0;
        end else begin
            rx_meta         <= rx;
            rx_sync         <= rx_meta;
            rx_prev         <= rx_sync;
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
            start_valid     <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Half a bit after the falling edge the line must still be low.
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            state <= RX_IDLE;
                        end else begin
                            state       <= RX_DATA;
                            bit_idx     <= '0;
                            start_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        if (bit_idx == 3'(UART_BITS - 1)) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt             <= '0;
                        state           <= RX_IDLE;
                        byte_valid      <= rx_sync;
                        frame_err_pulse <= !rx_sync;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed little-endian program over UART and writes it to imem.
// Holds the core in reset until the last word is written; any framing error is terminal until reset.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          MAX_WORDS    = 1024,
    parameter logic [31:0] ADDR_BASE    = 32'h0
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_n_reset,
    output logic        busy,
    output logic        done,
    output logic        frame_err
);
    logic [7:0]    rx_byte;
    logic          byte_valid, frame_err_pulse, start_valid;
    loader_state_t state;
    logic [1:0]    lane;
    logic [23:0]   acc;
    logic [31:0]   len, idx;
    logic [31:0]   word_next;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk            (clk),
        .n_reset        (n_reset),
        .rx             (rx),
        .rx_byte        (rx_byte),
        .byte_valid     (byte_valid),
        .frame_err_pulse(frame_err_pulse),
        .start_valid    (start_valid)
    );

    // First byte received ends up in bits [7:0] after four shifts.
    assign word_next = {rx_byte, acc};

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state       <= LEN;
            lane        <= '0;
            acc         <= '0;
            len         <= '0;
            idx         <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= ADDR_BASE;
            imem_wdata  <= '0;
            cpu_n_reset <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (byte_valid) begin
                acc  <= word_next[31:8];
                lane <= lane + 1'b1;
            end
            case (state)
                LEN, DATA: begin
                    if (start_valid) busy <= 1'b1;
                    if (frame_err_pulse) begin
                        state     <= ERR;
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                    end else if (state == LEN) begin
                        if (byte_valid && lane == 2'd3) begin
                            len <= word_next;
                            idx <= '0;
                            if (word_next == 32'd0) begin
                                state       <= DONE;
                                done        <= 1'b1;
                                cpu_n_reset <= 1'b1;
                                busy        <= 1'b0;
                            end else if (word_next > 32'(MAX_WORDS)) begin
                                state     <= ERR;
                                frame_err <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end else begin
                        if (byte_valid && lane == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ADDR_BASE + (idx << 2);
                            imem_wdata <= word_next;
                        end
                        // Bytes are many cycles apart, so the strobe cycle never overlaps a new byte.
                        if (imem_we) begin
                            idx <= idx + 32'd1;
                            if (idx == len - 32'd1) begin
                                state       <= DONE;
                                done        <= 1'b1;
                                cpu_n_reset <= 1'b1;
                                busy        <= 1'b0;
                            end
                        end
                    end
                end
                DONE: ;
                ERR: ;
                default: state <= ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with CLKS_PER_BIT=4, MAX_WORDS=4, ADDR_BASE=0.
module tb_prog_loader;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        cpu_n_reset, busy, done, frame_err;

    int checks = 0;
    int errors = 0;
    int wr_n = 0;
    logic [31:0] wr_addr [0:15];
    logic [31:0] wr_data [0:15];

    prog_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(4), .ADDR_BASE(32'h0)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_n_reset(cpu_n_reset),
        .busy       (busy),
        .done       (done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Write log; consecutive high strobes would appear as extra entries.
    always @(negedge clk) begin
        if (!n_reset) begin
            wr_n = 0;
        end else if (imem_we) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] = imem_addr;
                wr_data[wr_n] = imem_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            wait_clks(CPB);
        end
        rx = 1'b1;
        wait_clks(2 * CPB);
    endtask

    task automatic send_bytes(input logic [7:0] bs [], input int n);
        for (int i = 0; i < n; i++) send_byte(bs[i], 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        n_reset = 1'b0;
        rx = 1'b1;
        wait_clks(2);
        n_reset = 1'b1;
        @(negedge clk);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    endtask

    task automatic check_case2(input string pfx);
        check({pfx, "_wr_n"}, wr_n, 32'd2);
        check({pfx, "_addr0"}, wr_addr[0], 32'h0000_0000);
        check({pfx, "_data0"}, wr_data[0], 32'h0000_0013);
        check({pfx, "_addr1"}, wr_addr[1], 32'h0000_0004);
        check({pfx, "_data1"}, wr_data[1], 32'h0010_00B3);
        check({pfx, "_done"}, {31'd0, done}, 32'd1);
        check({pfx, "_cpu_n_reset"}, {31'd0, cpu_n_reset}, 32'd1);
        check({pfx, "_busy"}, {31'd0, busy}, 32'd0);
        check({pfx, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({pfx, "_hold_addr"}, imem_addr, 32'h0000_0004);
        check({pfx, "_hold_wdata"}, imem_wdata, 32'h0010_00B3);
    endtask

    logic [7:0] prog2 [] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'hB3, 8'h00, 8'h10, 8'h00};
    logic [7:0] zero4 [] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] five4 [] = '{8'h05, 8'h00, 8'h00, 8'h00};

    initial begin
        // Reset
        do_reset();

        // Two-word program, checking busy during the load
        send_byte(prog2[0], 1'b1);
        check("c2_busy_mid", {31'd0, busy}, 32'd1);
        check("c2_cpu_held", {31'd0, cpu_n_reset}, 32'd0);
        for (int i = 1; i < 12; i++) send_byte(prog2[i], 1'b1);
        wait_clks(4);
        check_case2("c2");
        send_byte(8'hAA, 1'b1);
        check("c2_ignore_after_done", wr_n, 32'd2);

        // Zero-length program
        do_reset();
        send_bytes(zero4, 4);
        check("c3_wr_n", wr_n, 32'd0);
        check("c3_done", {31'd0, done}, 32'd1);
        check("c3_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd1);
        check("c3_busy", {31'd0, busy}, 32'd0);

        // Oversize length
        do_reset();
        send_bytes(five4, 4);
        check("c4_frame_err", {31'd0, frame_err}, 32'd1);
        check("c4_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        check("c4_done", {31'd0, done}, 32'd0);
        check("c4_busy", {31'd0, busy}, 32'd0);
        check("c4_wr_n", wr_n, 32'd0);

        // Stop bit low during DATA
        do_reset();
        send_bytes(prog2, 8);
        check("c5_first_write", wr_n, 32'd1);
        send_byte(8'hB3, 1'b0);
        check("c5_frame_err", {31'd0, frame_err}, 32'd1);
        for (int i = 8; i < 12; i++) send_byte(prog2[i], 1'b1);
        check("c5_no_more_writes", wr_n, 32'd1);
        check("c5_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        check("c5_done", {31'd0, done}, 32'd0);

        // One-cycle glitch, then mid-load reset and a full reload
        do_reset();
        rx = 1'b0;
        wait_clks(1);
        rx = 1'b1;
        wait_clks(4 * CPB);
        check("c6_glitch_busy", {31'd0, busy}, 32'd0);
        check("c6_glitch_err", {31'd0, frame_err}, 32'd0);
        send_bytes(prog2, 6);
        check("c6_partial_busy", {31'd0, busy}, 32'd1);
        do_reset();
        send_bytes(prog2, 12);
        wait_clks(4);
        check_case2("c6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
